// File: rtl/mem_a_loader_if.sv
// Host byte stream and memory-A write port of the memory-A loader.
// master: host/memory side, slave: the loader itself.
interface mem_a_loader_if #(
  parameter int BYTE_W = 8,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 6
);
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [WORD_W-1:0] wdata_a;

  modport master (output in_data, in_valid, input in_ready, we_a, addr_a, wdata_a);
  modport slave  (input in_data, in_valid, output in_ready, we_a, addr_a, wdata_a);
endinterface

// File: rtl/mem_a_loader.sv
// Packs a big-endian byte stream into words and writes one DEPTH-word frame into memory A.
// Optional inter-byte gap timeout: define LOADER_TIMEOUT_EN.
module mem_a_loader #(
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 2,
  parameter int DEPTH          = 64,
  parameter int TIMEOUT_CYC    = 1000,
  localparam int WORD_W        = BYTE_W * BYTES_PER_WORD,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  mem_a_loader_if.slave   bus,
  input  logic            rearm,
  output logic            busy,
  output logic            frame_done,
  output logic [ADDR_W:0] word_count,
  output logic            err_timeout
);
  localparam int BIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {COLLECT = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_t;

  state_t                   state_r, state_nxt_s;
  logic [BIDX_W-1:0]        byte_idx_r, byte_idx_nxt_s;
  logic [ADDR_W-1:0]        word_idx_r, word_idx_nxt_s;
  logic [ADDR_W:0]          word_count_r, word_count_nxt_s;
  logic [WORD_W-BYTE_W-1:0] pack_r, pack_nxt_s;
  logic [WORD_W-1:0]        packed_s;
  logic                     we_a_r, we_a_nxt_s;
  logic [ADDR_W-1:0]        addr_a_r, addr_a_nxt_s;
  logic [WORD_W-1:0]        wdata_a_r, wdata_a_nxt_s;
  logic                     frame_done_r, frame_done_nxt_s;
  logic                     err_timeout_r, err_timeout_nxt_s;
  logic                     busy_r, in_ready_r;
  logic                     accept_s, timeout_s;

  assign accept_s = bus.in_valid & in_ready_r;
  // Earlier bytes sit in the upper part so the first byte ends up in the MSBs.
  assign packed_s = {pack_r, bus.in_data};

`ifdef LOADER_TIMEOUT_EN
  localparam int GAP_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             gap_tick_s;

  assign gap_tick_s = (state_r == COLLECT) && !accept_s &&
                      ((byte_idx_r != BIDX_W'(0)) || (word_idx_r != ADDR_W'(0)));
  assign timeout_s  = gap_tick_s && (gap_cnt_r == GAP_W'(TIMEOUT_CYC - 1));

  // Idle-gap counter; cleared by any accepted byte or an empty frame.
  always_ff @(posedge clk) begin
    if (reset || timeout_s || !gap_tick_s) begin
      gap_cnt_r <= GAP_W'(0);
    end else begin
      gap_cnt_r <= gap_cnt_r + GAP_W'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      COLLECT: if (accept_s && (byte_idx_r == LAST_BYTE)) state_nxt_s = WRITE;
               else                                        state_nxt_s = COLLECT;
      WRITE:   if (word_idx_r == LAST_WORD)                state_nxt_s = DONE;
               else                                        state_nxt_s = COLLECT;
      DONE:    if (rearm)                                  state_nxt_s = COLLECT;
               else                                        state_nxt_s = DONE;
      default:                                             state_nxt_s = COLLECT;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    byte_idx_nxt_s    = byte_idx_r;
    word_idx_nxt_s    = word_idx_r;
    word_count_nxt_s  = word_count_r;
    pack_nxt_s        = pack_r;
    we_a_nxt_s        = 1'b0;
    addr_a_nxt_s      = addr_a_r;
    wdata_a_nxt_s     = wdata_a_r;
    frame_done_nxt_s  = 1'b0;
    err_timeout_nxt_s = 1'b0;
    case (state_r)
      COLLECT: begin
        if (timeout_s) begin
          byte_idx_nxt_s    = BIDX_W'(0);
          word_idx_nxt_s    = ADDR_W'(0);
          word_count_nxt_s  = (ADDR_W + 1)'(0);
          err_timeout_nxt_s = 1'b1;
        end else if (accept_s) begin
          pack_nxt_s = packed_s[WORD_W-BYTE_W-1:0];
          if (byte_idx_r == LAST_BYTE) begin
            byte_idx_nxt_s = BIDX_W'(0);
            we_a_nxt_s     = 1'b1;
            addr_a_nxt_s   = word_idx_r;
            wdata_a_nxt_s  = packed_s;
          end else begin
            byte_idx_nxt_s = byte_idx_r + BIDX_W'(1);
          end
        end else begin
          byte_idx_nxt_s = byte_idx_r;
        end
      end
      WRITE: begin
        // Word index wraps to 0 naturally after the last word.
        word_idx_nxt_s   = word_idx_r + ADDR_W'(1);
        word_count_nxt_s = word_count_r + (ADDR_W + 1)'(1);
        frame_done_nxt_s = (word_idx_r == LAST_WORD);
      end
      DONE: begin
        if (rearm) begin
          word_count_nxt_s = (ADDR_W + 1)'(0);
          byte_idx_nxt_s   = BIDX_W'(0);
        end else begin
          word_count_nxt_s = word_count_r;
        end
      end
      default: begin
        byte_idx_nxt_s = BIDX_W'(0);
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx_r    <= BIDX_W'(0);
      word_idx_r    <= ADDR_W'(0);
      word_count_r  <= (ADDR_W + 1)'(0);
      pack_r        <= (WORD_W - BYTE_W)'(0);
      we_a_r        <= 1'b0;
      addr_a_r      <= ADDR_W'(0);
      wdata_a_r     <= WORD_W'(0);
      frame_done_r  <= 1'b0;
      err_timeout_r <= 1'b0;
      busy_r        <= 1'b1;
      in_ready_r    <= 1'b1;
    end else begin
      byte_idx_r    <= byte_idx_nxt_s;
      word_idx_r    <= word_idx_nxt_s;
      word_count_r  <= word_count_nxt_s;
      pack_r        <= pack_nxt_s;
      we_a_r        <= we_a_nxt_s;
      addr_a_r      <= addr_a_nxt_s;
      wdata_a_r     <= wdata_a_nxt_s;
      frame_done_r  <= frame_done_nxt_s;
      err_timeout_r <= err_timeout_nxt_s;
      busy_r        <= (state_nxt_s != DONE);
      in_ready_r    <= (state_nxt_s == COLLECT);
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.we_a     = we_a_r;
  assign bus.addr_a   = addr_a_r;
  assign bus.wdata_a  = wdata_a_r;
  assign busy         = busy_r;
  assign frame_done   = frame_done_r;
  assign word_count   = word_count_r;
  assign err_timeout  = err_timeout_r;
endmodule

// File: tb/tb_mem_a_loader.sv
// Self-checking bench for mem_a_loader: randomized stream gaps/data against a
// frame-level model (word i = {byte 2i, byte 2i+1} at address i).
module tb_mem_a_loader;
`ifdef LOADER_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1000;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rearm = 1'b0;
  logic       busy, frame_done, err_timeout;
  logic [6:0] word_count;

  mem_a_loader_if #(.BYTE_W(8), .WORD_W(16), .ADDR_W(6)) bus ();

  mem_a_loader #(.BYTE_W(8), .BYTES_PER_WORD(2), .DEPTH(64), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset), .bus(bus), .rearm(rearm), .busy(busy),
    .frame_done(frame_done), .word_count(word_count), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
    int          cyc;
    logic        busy;
    logic [6:0]  wc;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] stim[$];
  int         cyc = 0;
  int         fd_cnt = 0;
  int         err_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // Write monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (bus.we_a === 1'b1) wq.push_back('{bus.addr_a, bus.wdata_a, cyc, busy, word_count});
    if (frame_done === 1'b1) fd_cnt++;
    if (err_timeout === 1'b1) err_cnt++;
  end

  function automatic logic [15:0] exp_word(int i);
    return {stim[2*i], stim[2*i+1]};
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00; rearm = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    wq.delete(); fd_cnt = 0; err_cnt = 0;
  endtask

  // Offers stim[first..first+n-1]; each byte is held until accepted.
  task automatic send_stim(input int first, input int n, input bit gaps, output int lost);
    lost = 0;
    for (int i = first; i < first + n; i++) begin
      int budget;
      int g;
      g = 0;
      while (gaps && g < 6 && $urandom_range(1, 0) == 0) begin
        bus.in_valid = 1'b0; @(negedge clk); g++;
      end
      bus.in_data = stim[i]; bus.in_valid = 1'b1;
      budget = 50;
      while (budget > 0 && bus.in_ready !== 1'b1) begin @(negedge clk); budget--; end
      if (budget == 0) lost++;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++;
    if ({busy, bus.in_ready, bus.we_a, frame_done, err_timeout} !== 5'b11000) begin
      n_fail++; $display("FAIL reset_flags got=%b want=11000", {busy, bus.in_ready, bus.we_a, frame_done, err_timeout});
    end
    n_checks++;
    if ({bus.addr_a, bus.wdata_a, word_count} !== 29'd0) begin
      n_fail++; $display("FAIL reset_regs addr=%0d data=%h wc=%0d want 0", bus.addr_a, bus.wdata_a, word_count);
    end
  endtask

  task automatic test_back_to_back();
    int lost;
    do_reset(2);
    stim.delete();
    for (int i = 0; i < 128; i++) stim.push_back(8'(i));
    send_stim(0, 128, 1'b0, lost);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (lost != 0 || wq.size() != 64) begin
      n_fail++; $display("FAIL b2b_count writes=%0d lost=%0d want 64/0", wq.size(), lost);
    end
    for (int i = 0; i < wq.size() && i < 64; i++) begin
      n_checks++;
      if (wq[i].addr !== 6'(i) || wq[i].data !== exp_word(i) || wq[i].wc !== 7'(i) || wq[i].busy !== 1'b1) begin
        n_fail++; $display("FAIL b2b_word%0d addr=%0d data=%h wc=%0d busy=%b want %0d/%h/%0d/1",
                           i, wq[i].addr, wq[i].data, wq[i].wc, wq[i].busy, i, exp_word(i), i);
      end
      if (i > 0) begin
        n_checks++;
        if (wq[i].cyc - wq[i-1].cyc != 3) begin
          n_fail++; $display("FAIL b2b_spacing%0d got=%0d want=3", i, wq[i].cyc - wq[i-1].cyc);
        end
      end
    end
    n_checks++;
    if (wq.size() == 64 && ({wq[0].addr, wq[0].data} !== 22'h0_0001 || {wq[63].addr, wq[63].data} !== {6'd63, 16'h7E7F})) begin
      n_fail++; $display("FAIL b2b_ends first=%0d/%h last=%0d/%h want 0/0001 63/7e7f",
                         wq[0].addr, wq[0].data, wq[63].addr, wq[63].data);
    end
    n_checks++;
    if (fd_cnt != 1 || busy !== 1'b0 || word_count !== 7'd64 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done fd=%0d busy=%b wc=%0d rdy=%b want 1/0/64/0", fd_cnt, busy, word_count, bus.in_ready);
    end
  endtask

  task automatic test_done_hold_rearm();
    int lost;
    bus.in_data = 8'hAA; bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b0 || wq.size() != 64) begin
        n_fail++; $display("FAIL hold_cyc%0d rdy=%b busy=%b writes=%0d want 0/0/64", i, bus.in_ready, busy, wq.size());
      end
    end
    n_checks++;
    if (fd_cnt != 1) begin n_fail++; $display("FAIL hold_fd got=%0d want=1", fd_cnt); end
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || word_count !== 7'd0) begin
      n_fail++; $display("FAIL rearm_busy busy=%b wc=%0d want 1/0", busy, word_count);
    end
    stim.delete(); stim.push_back(8'hAA); stim.push_back(8'h55);
    wq.delete();
    send_stim(0, 2, 1'b0, lost);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (lost != 0 || wq.size() != 1 || wq[0].addr !== 6'd0 || wq[0].data !== 16'hAA55 || word_count !== 7'd1) begin
      n_fail++; $display("FAIL rearm_write writes=%0d addr=%0d data=%h wc=%0d want 1/0/aa55/1",
                         wq.size(), wq.size() > 0 ? wq[0].addr : 6'd0, wq.size() > 0 ? wq[0].data : 16'd0, word_count);
    end
  endtask

  task automatic test_random_gaps();
    int lost;
    do_reset(2);
    stim.delete();
    for (int i = 0; i < 128; i++) stim.push_back(8'(i));
    send_stim(0, 128, 1'b1, lost);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (lost != 0 || wq.size() != 64) begin
      n_fail++; $display("FAIL gaps_count writes=%0d lost=%0d want 64/0", wq.size(), lost);
    end
    for (int i = 0; i < wq.size() && i < 64; i++) begin
      n_checks++;
      if (wq[i].addr !== 6'(i) || wq[i].data !== exp_word(i) || wq[i].wc !== 7'(i) || wq[i].busy !== 1'b1) begin
        n_fail++; $display("FAIL gaps_word%0d addr=%0d data=%h wc=%0d busy=%b want %0d/%h/%0d/1",
                           i, wq[i].addr, wq[i].data, wq[i].wc, wq[i].busy, i, exp_word(i), i);
      end
    end
    n_checks++;
    if (fd_cnt != 1 || busy !== 1'b0 || word_count !== 7'd64) begin
      n_fail++; $display("FAIL gaps_done fd=%0d busy=%b wc=%0d want 1/0/64", fd_cnt, busy, word_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int lost;
    do_reset(2);
    stim.delete();
    for (int i = 0; i < 22; i++) stim.push_back(8'($urandom));
    send_stim(0, 20, 1'b1, lost);
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (lost != 0 || word_count !== 7'd10) begin
      n_fail++; $display("FAIL midrst_pre wc=%0d lost=%0d want 10/0", word_count, lost);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || word_count !== 7'd0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_state busy=%b wc=%0d rdy=%b want 1/0/1", busy, word_count, bus.in_ready);
    end
    wq.delete();
    send_stim(20, 2, 1'b0, lost);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (lost != 0 || wq.size() != 1 || wq[0].addr !== 6'd0 || wq[0].data !== exp_word(10)) begin
      n_fail++; $display("FAIL midrst_write writes=%0d addr=%0d data=%h want 1/0/%h",
                         wq.size(), wq.size() > 0 ? wq[0].addr : 6'd0, wq.size() > 0 ? wq[0].data : 16'd0, exp_word(10));
    end
  endtask

  task automatic test_rearm_ignored();
    int lost, lost2;
    do_reset(2);
    stim.delete();
    for (int i = 0; i < 128; i++) stim.push_back(8'($urandom));
    send_stim(0, 10, 1'b0, lost);
    bus.in_valid = 1'b0;
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || word_count !== 7'd5) begin
      n_fail++; $display("FAIL rearm_ign_mid busy=%b wc=%0d want 1/5", busy, word_count);
    end
    send_stim(10, 118, 1'b1, lost2);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (lost + lost2 != 0 || wq.size() != 64 || fd_cnt != 1 || word_count !== 7'd64) begin
      n_fail++; $display("FAIL rearm_ign_frame writes=%0d fd=%0d wc=%0d want 64/1/64", wq.size(), fd_cnt, word_count);
    end
    for (int i = 0; i < wq.size() && i < 64; i++) begin
      n_checks++;
      if (wq[i].addr !== 6'(i) || wq[i].data !== exp_word(i)) begin
        n_fail++; $display("FAIL rearm_ign_word%0d addr=%0d data=%h want %0d/%h", i, wq[i].addr, wq[i].data, i, exp_word(i));
      end
    end
  endtask

  task automatic test_timeout();
    int lost, first_k;
    do_reset(2);
    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back(8'($urandom));
    stim.push_back(8'h12); stim.push_back(8'h34);
    send_stim(0, 3, 1'b0, lost);
    bus.in_valid = 1'b0;
    first_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (err_timeout === 1'b1 && first_k == 0) first_k = k;
    end
`ifdef LOADER_TIMEOUT_EN
    n_checks++;
    if (lost != 0 || first_k != TO_CYC || err_cnt != 1) begin
      n_fail++; $display("FAIL timeout_pulse at=%0d count=%0d want %0d/1", first_k, err_cnt, TO_CYC);
    end
    n_checks++;
    if (word_count !== 7'd0 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL timeout_state wc=%0d busy=%b rdy=%b want 0/1/1", word_count, busy, bus.in_ready);
    end
    wq.delete();
    send_stim(3, 2, 1'b0, lost);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (lost != 0 || wq.size() != 1 || wq[0].addr !== 6'd0 || wq[0].data !== 16'h1234) begin
      n_fail++; $display("FAIL timeout_fresh writes=%0d addr=%0d data=%h want 1/0/1234",
                         wq.size(), wq.size() > 0 ? wq[0].addr : 6'd0, wq.size() > 0 ? wq[0].data : 16'd0);
    end
`else
    n_checks++;
    if (lost != 0 || first_k != 0 || err_cnt != 0 || word_count !== 7'd1) begin
      n_fail++; $display("FAIL notimeout_wait err_at=%0d count=%0d wc=%0d want 0/0/1", first_k, err_cnt, word_count);
    end
    send_stim(3, 1, 1'b0, lost);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (lost != 0 || wq.size() != 2 || wq[1].addr !== 6'd1 || wq[1].data !== {stim[2], 8'h12}) begin
      n_fail++; $display("FAIL notimeout_resume writes=%0d addr=%0d data=%h want 2/1/%h",
                         wq.size(), wq.size() > 1 ? wq[1].addr : 6'd0, wq.size() > 1 ? wq[1].data : 16'd0, {stim[2], 8'h12});
    end
`endif
  endtask

  initial begin
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    test_reset();
    test_back_to_back();
    test_done_hold_rearm();
    test_random_gaps();
    test_reset_mid_frame();
    test_rearm_ignored();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_a_loader.md
Name: mem_a_loader

Overview:
- Writer side of memory A: takes a host byte stream (valid/ready), packs pairs of bytes into 16-bit words and writes a 64-word frame into memory A at addresses 0..63.
- Drives the busy flag seen by the memory-A reader/control unit. busy stays high until a complete frame is written.
- Holds memory A stable until the consumer re-arms it for the next frame.

Parameters:
- BYTE_W, 8, width of one input byte
- BYTES_PER_WORD, 2, bytes packed per memory word; WORD_W = BYTE_W*BYTES_PER_WORD = 16
- DEPTH, 64, words per frame; ADDR_W = clog2(DEPTH) = 6
- TIMEOUT_CYC, 1000, inter-byte gap limit in cycles; used only with LOADER_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_data  in  BYTE_W  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte
- rearm  in  1  one-cycle pulse: consumer finished with memory A; begin the next frame
- we_a  out  1  memory A write enable
- addr_a  out  ADDR_W  memory A write address
- wdata_a  out  WORD_W  memory A write data
- busy  out  1  high while memory A is incomplete or being loaded
- frame_done  out  1  one-cycle pulse when word DEPTH-1 is written
- word_count  out  ADDR_W+1  words written in the current frame (0..64)
- err_timeout  out  1  one-cycle pulse when a partial frame is discarded

Interface rule: reset reset, synchronous, active-high; clock clk.

Behaviour:
- States: COLLECT, WRITE, DONE. Reset state is COLLECT.
- Reset values:
  - byte index = 0, word index = 0, word_count = 0
  - we_a = 0, addr_a = 0, wdata_a = 0, frame_done = 0, err_timeout = 0
  - busy = 1, in_ready = 1
- Byte acceptance: a byte is accepted only on a cycle where in_valid & in_ready are both high. in_ready = (state == COLLECT).
- Packing: bytes are big-endian. The first accepted byte of a word lands in wdata bits [15:8], the second in [7:0].
- COLLECT: on acceptance of byte index BYTES_PER_WORD-1, go to WRITE at the next edge and reset byte index to 0. Otherwise increment byte index.
- WRITE (exactly one cycle):
  - we_a = 1, addr_a = word index, wdata_a = packed word.
  - At the following edge: word index +1 and word_count +1.
  - If word index was DEPTH-1, go to DONE; otherwise return to COLLECT.
  - Peak throughput is 2 bytes per 3 cycles.
- Output timing: we_a, addr_a and wdata_a are registered and valid during the WRITE cycle. addr_a and wdata_a hold their last values when we_a = 0.
- DONE:
  - busy = 0, in_ready = 0.
  - frame_done = 1 only in the first DONE cycle.
  - word_count holds 64. The word index wraps to 0.
- rearm:
  - In DONE: next state is COLLECT, busy = 1, word_count = 0, byte index = 0.
  - In COLLECT or WRITE: ignored.
- busy: rises in the cycle after rearm is sampled and falls on entry to DONE. It never toggles mid-frame.
- Upstream input: in_valid held high while in_ready = 0 is legal. The byte is not consumed and in_data must be held by upstream.
- Reset mid-frame: the partial frame is discarded. All state returns to reset values. Words already written stay in memory but are not valid.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- With the macro defined:
  - In COLLECT, a gap counter runs whenever the frame is partial (byte index != 0 or word index != 0) and no byte is accepted that cycle. It clears on every accepted byte.
  - When the counter reaches TIMEOUT_CYC: err_timeout pulses for 1 cycle, byte index, word index and word_count clear to 0, and the state stays COLLECT with busy = 1.
  - The counter is idle while the frame is empty.
- Without the macro: no counter is built, err_timeout is tied to 0, and a partial frame waits indefinitely.

Test Plan:
- Reset, then stream 128 bytes 0x00..0x7F with in_valid held high -> 64 writes, the first {addr 0, data 0x0001}, the last {addr 63, data 0x7E7F}. Exactly 3 cycles between we_a pulses. frame_done pulses once, then busy = 0 and word_count = 64.
- In DONE, keep in_valid = 1 for 20 cycles -> in_ready = 0 and no we_a. Pulse rearm -> busy = 1 next cycle. The next byte pair 0xAA,0x55 writes {addr 0, data 0xAA55}.
- Random in_valid gaps (about 50% duty) over a full frame -> same memory image as the back-to-back case. busy is held at 1 throughout and word_count increments on each write.
- After 10 words, assert reset for 1 cycle -> busy = 1, word_count = 0. The next pair writes addr 0.
- rearm pulsed during COLLECT at word 5 -> no effect: the frame continues and completes at addr 63.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYC = 16: send 3 bytes, then idle 16 cycles -> err_timeout pulses once and word_count = 0. A fresh pair 0x12,0x34 then writes {addr 0, data 0x1234}.
